// File: rtl/halflife_if.sv
// halflife_if
//   Bundles the control and status signals between halflife_driver and its
//   surroundings: run control (start/abort/init_val), the counter-facing
//   strobes (load/load_val/down/up), the counter read-back (count_in) and
//   run status (busy/done/err/halflives).
//   master : the driver side (drives the strobes and status).
//   slave  : the wrapper/counter side (drives run control and read-back).
interface halflife_if;
    logic       start;
    logic       abort;
    logic [3:0] init_val;
    logic [3:0] count_in;
    logic       load;
    logic [3:0] load_val;
    logic       down;
    logic       up;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] halflives;

    modport master (
        input  start, abort, init_val, count_in,
        output load, load_val, down, up, busy, done, err, halflives
    );

    modport slave (
        output start, abort, init_val, count_in,
        input  load, load_val, down, up, busy, done, err, halflives
    );
endinterface

// File: rtl/halflife_driver.sv
// halflife_driver
//   Loads a start value into the half-life counter, then every HL_TICKS
//   cycles steps it down with single down pulses to floor(value/2), checking
//   the counter's read-back after every strobe. Pulses done when the count
//   reaches zero, holds err if the counter ever disagrees.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (deasserted synchronously inside)
//   bus   : halflife_if.master (start/abort/init_val/count_in in,
//           load/load_val/down/up/busy/done/err/halflives out)
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | load strobe with the latched start value
// CHECK  | counter must now read the loaded value
// WAIT   | counting out one half-life period
// STEP   | at target -> next period / done, else issue one down pulse
// SETTLE | counter must now read the expected decremented value
// DONE   | one-cycle done pulse
// ERR    | counter mismatch, held until abort or reset
module halflife_driver #(
    parameter int unsigned HL_TICKS = 1000
) (
    input logic        clk,
    input logic        rst_n,
    halflife_if.master bus
);

    localparam logic [15:0] PERIOD_TC = 16'(HL_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_WAIT, S_STEP, S_SETTLE, S_DONE, S_ERR
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  rst_sync;
    logic        rst_int_n;
    logic [3:0]  val;
    logic [3:0]  target;
    logic [3:0]  expected;
    logic [15:0] period;
    logic [2:0]  hl_cnt;
    logic        period_tc;
    logic        at_target;

    // Assert reaches every flop immediately; release is retimed to clk so
    // the FSM never leaves reset on a partial edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign period_tc = (period == PERIOD_TC);
    assign at_target = (bus.count_in == target);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (bus.start) state_nxt = (bus.init_val == 4'd0) ? S_DONE : S_LOAD;
                S_LOAD:   state_nxt = S_CHECK;
                S_CHECK:  state_nxt = (bus.count_in == val) ? S_WAIT : S_ERR;
                S_WAIT:   if (period_tc) state_nxt = S_STEP;
                S_STEP:   begin
                    if (at_target) state_nxt = (target == 4'd0) ? S_DONE : S_WAIT;
                    else           state_nxt = S_SETTLE;
                end
                S_SETTLE: state_nxt = (bus.count_in == expected) ? S_STEP : S_ERR;
                S_DONE:   state_nxt = S_IDLE;
                S_ERR:    state_nxt = S_ERR;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // down is qualified by the live read-back so the pulse is issued in the
    // same STEP cycle that decides the counter is still above target.
    always_comb begin
        bus.load = 1'b0;
        bus.down = 1'b0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        bus.err  = 1'b0;
        case (state)
            S_IDLE:   ;
            S_LOAD:   begin bus.load = 1'b1; bus.busy = 1'b1; end
            S_STEP:   begin bus.down = ~at_target; bus.busy = 1'b1; end
            S_DONE:   bus.done = 1'b1;
            S_ERR:    begin bus.err = 1'b1; bus.busy = 1'b1; end
            default:  bus.busy = 1'b1;
        endcase
    end

    assign bus.up        = 1'b0;
    assign bus.load_val  = val;
    assign bus.halflives = hl_cnt;

    // Datapath updates are suppressed under abort so halflives keeps the
    // value reached before the abort.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            val      <= 4'd0;
            target   <= 4'd0;
            expected <= 4'd0;
            period   <= 16'd0;
            hl_cnt   <= 3'd0;
        end else if (!bus.abort) begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        val    <= bus.init_val;
                        hl_cnt <= 3'd0;
                    end
                end
                S_CHECK: period <= 16'd0;
                S_WAIT: begin
                    if (period_tc) begin
                        target <= bus.count_in >> 1;
                        if (hl_cnt != 3'd7) hl_cnt <= hl_cnt + 3'd1;
                    end else begin
                        period <= period + 16'd1;
                    end
                end
                S_STEP: begin
                    if (at_target) period   <= 16'd0;
                    else           expected <= bus.count_in - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_halflife_driver.sv
module tb_halflife_driver;

    localparam int EV_LOAD = 1;
    localparam int EV_DOWN = 2;
    localparam int EV_DONE = 3;
    localparam int EV_ERR  = 4;

    typedef struct {
        int         kind;
        logic [3:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cnt = 4'd0;
    int         dn_num = 0;
    logic       model_clr = 1'b0;
    logic       ign_load = 1'b0;
    logic       ign_down2 = 1'b0;

    int  checks = 0;
    int  failures = 0;
    ev_t sb_q[$];

    halflife_if hl();

    halflife_driver #(.HL_TICKS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hl.master)
    );

    always #5 clk = ~clk;

    assign hl.count_in = cnt;

    // Counter model: registers load/down on the same edge the driver
    // drives them; fault modes drop a load or the second down.
    always @(posedge clk) begin
        if (model_clr) begin
            cnt    <= 4'd0;
            dn_num <= 0;
        end else if (hl.load) begin
            if (!ign_load) cnt <= hl.load_val;
        end else if (hl.down) begin
            dn_num <= dn_num + 1;
            if (!(ign_down2 && dn_num == 1)) cnt <= cnt - 4'd1;
        end
    end

    task automatic push_ev(input int k, input logic [3:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic observe(input int k, input logic [3:0] d);
        ev_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got kind=%0d data=%0d, required no event", k, d);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != k || e.data != d) begin
                failures++;
                $display("FAIL sb_event: got kind=%0d data=%0d, required kind=%0d data=%0d",
                         k, d, e.kind, e.data);
            end
        end
    endtask

    // Monitor: every strobe/pulse the driver presents is matched in order
    // against the expected-event queue.
    initial begin
        logic prev_down = 1'b0;
        logic prev_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (hl.load || hl.down) begin
                    checks++;
                    if (hl.load && hl.down) begin
                        failures++;
                        $display("FAIL load_down_overlap: load=%0b down=%0b, required not both", hl.load, hl.down);
                    end
                end
                if (hl.down) begin
                    checks++;
                    if (prev_down) begin
                        failures++;
                        $display("FAIL down_gap: down high on consecutive cycles, required a gap");
                    end
                end
                if (hl.load) observe(EV_LOAD, hl.load_val);
                if (hl.down) observe(EV_DOWN, cnt);
                if (hl.done) observe(EV_DONE, {1'b0, hl.halflives});
                if (hl.err && !prev_err) observe(EV_ERR, 4'd0);
            end
            prev_down = hl.down;
            prev_err  = hl.err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return hl.done;
            1:       return hl.err;
            2:       return hl.down;
            default: return (cnt == 4'd7 && hl.halflives == 3'd1);
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string name);
        int n = 0;
        while (!cond(which) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!cond(which)) begin
            failures++;
            $display("FAIL %s_timeout: condition not seen within %0d cycles, required seen", name, budget);
        end
    endtask

    task automatic start_run(input logic [3:0] v);
        hl.init_val = v;
        hl.start    = 1'b1;
        tick();
        hl.start    = 1'b0;
    endtask

    task automatic clr_model();
        model_clr = 1'b1;
        tick();
        model_clr = 1'b0;
    endtask

    function automatic int outs();
        return int'({hl.load, hl.load_val, hl.down, hl.up, hl.busy, hl.done, hl.err, hl.halflives});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        hl.start    = 1'b0;
        hl.abort    = 1'b0;
        hl.init_val = 4'd0;
        model_clr   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 0);
        #2 rst_n = 1'b1;
        repeat (4) tick();
        model_clr = 1'b0;
        check("idle_outputs", outs(), 0);

        // Normal run: 12 -> 6 -> 3 -> 1 -> 0
        push_ev(EV_LOAD, 4'd12);
        for (int v = 12; v >= 1; v--) push_ev(EV_DOWN, 4'(v));
        push_ev(EV_DONE, 4'd4);
        start_run(4'd12);
        check("normal_load_c1", int'(hl.load), 1);
        check("normal_busy_c1", int'(hl.busy), 1);
        wait_for(0, 120, "normal_done");
        check("normal_halflives", int'(hl.halflives), 4);
        check("normal_busy_at_done", int'(hl.busy), 0);
        check("normal_err", int'(hl.err), 0);
        check("normal_count", int'(cnt), 0);
        tick();
        check("normal_done_one_cycle", int'(hl.done), 0);

        // Zero start
        push_ev(EV_DONE, 4'd0);
        start_run(4'd0);
        check("zero_done_c1", int'(hl.done), 1);
        check("zero_load_c1", int'(hl.load), 0);
        check("zero_halflives", int'(hl.halflives), 0);
        tick();
        check("zero_idle_busy", int'(hl.busy), 0);

        // Load fault: counter ignores load
        ign_load = 1'b1;
        clr_model();
        push_ev(EV_LOAD, 4'd5);
        push_ev(EV_ERR, 4'd0);
        start_run(4'd5);
        tick();
        check("loadf_err_c2", int'(hl.err), 0);
        tick();
        check("loadf_err_c3", int'(hl.err), 1);
        check("loadf_busy_c3", int'(hl.busy), 1);
        repeat (3) tick();
        check("loadf_err_held", int'(hl.err), 1);
        hl.abort = 1'b1;
        tick();
        hl.abort = 1'b0;
        check("loadf_abort_err", int'(hl.err), 0);
        check("loadf_abort_busy", int'(hl.busy), 0);
        ign_load = 1'b0;

        // Down fault: counter ignores the second down
        ign_down2 = 1'b1;
        clr_model();
        push_ev(EV_LOAD, 4'd8);
        push_ev(EV_DOWN, 4'd8);
        push_ev(EV_DOWN, 4'd7);
        push_ev(EV_ERR, 4'd0);
        start_run(4'd8);
        wait_for(1, 60, "downf_err");
        repeat (10) tick();
        check("downf_err_held", int'(hl.err), 1);
        check("downf_down_count", dn_num, 2);
        hl.abort = 1'b1;
        tick();
        hl.abort = 1'b0;
        check("downf_abort_busy", int'(hl.busy), 0);
        ign_down2 = 1'b0;

        // Mid-run abort during the second WAIT
        push_ev(EV_LOAD, 4'd15);
        for (int v = 15; v >= 8; v--) push_ev(EV_DOWN, 4'(v));
        start_run(4'd15);
        wait_for(3, 80, "abort_first_period");
        tick();
        tick();
        check("abort_wait_down", int'(hl.down), 0);
        hl.abort = 1'b1;
        tick();
        hl.abort = 1'b0;
        check("abort_busy", int'(hl.busy), 0);
        check("abort_halflives", int'(hl.halflives), 1);
        tick();
        check("abort_halflives_held", int'(hl.halflives), 1);

        push_ev(EV_LOAD, 4'd2);
        push_ev(EV_DOWN, 4'd2);
        push_ev(EV_DOWN, 4'd1);
        push_ev(EV_DONE, 4'd2);
        start_run(4'd2);
        check("restart_halflives_clr", int'(hl.halflives), 0);
        wait_for(0, 60, "restart_done");
        check("restart_halflives", int'(hl.halflives), 2);
        tick();

        // Async reset asserted mid-SETTLE
        push_ev(EV_LOAD, 4'd4);
        push_ev(EV_DOWN, 4'd4);
        start_run(4'd4);
        wait_for(2, 40, "rst_first_down");
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) tick();
        check("post_reset_outputs", outs(), 0);
        push_ev(EV_LOAD, 4'd3);
        push_ev(EV_DOWN, 4'd3);
        push_ev(EV_DOWN, 4'd2);
        push_ev(EV_DOWN, 4'd1);
        push_ev(EV_DONE, 4'd2);
        start_run(4'd3);
        wait_for(0, 60, "post_reset_done");
        check("post_reset_halflives", int'(hl.halflives), 2);
        repeat (3) tick();

        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
